spi_flash_read: RTL
===================

SPI_FLASH_READ -- requirements
Module: spi_flash_read

Interface
REQ-001 Parameter: DIV, default 1, SCK half-period in wb_clk cycles; legal range 1..255.
REQ-002 wb_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 wb_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cyc  input  1  read request from the bus arbiter's shared (x) port.
REQ-005 adr  input  32  byte address; only adr[23:0] is used.
REQ-006 ack  output  1  one-cycle completion pulse.
REQ-007 rdt  output  32  read data; valid only while ack=1.
REQ-008 busy  output  1  high whenever a transaction is in progress.
REQ-009 spi_cs_n  output  1  flash chip select, active-low.
REQ-010 spi_sck  output  1  SPI clock, mode 0 (idle low).
REQ-011 spi_mosi  output  1  command/address to flash, MSB first.
REQ-012 spi_miso  input  1  data from flash.

Function
REQ-013 States: IDLE, SHIFT, DONE; busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-014 IDLE: cyc=1 sampled -> latch adr[23:0], load 64-bit frame {8'h03, adr[23:0], 32 don't-care}, go to SHIFT, spi_cs_n=0 from the next cycle.
REQ-015 SHIFT: 64 bit periods; each = DIV cycles sck=0 then DIV cycles sck=1; mosi changes only while sck=0 (at entry, and on each edge that drives sck 1->0).
REQ-016 miso SHALL be sampled on the wb_clk edge that drives sck 0->1; only bits 33..64 are stored.
REQ-017 Bits 1..32 drive mosi; during bits 33..64, mosi = 0.
REQ-018 Data assembly: received bytes B0..B3 in arrival order, each MSB first; rdt = {B3,B2,B1,B0} (little-endian word).
REQ-019 After the final high phase, go to DONE: spi_cs_n=1, spi_sck=0, ack=1, rdt=assembled word for exactly one cycle; then IDLE.
REQ-020 rdt SHALL be 32'h0 whenever ack=0.
REQ-021 Latency: ack high in the cycle following rising edge number 2+128*DIV counted from (and excluding) the edge that sampled cyc in IDLE (DIV=1: edge 130).
REQ-022 cyc is sampled only in IDLE; deassertion of cyc or change of adr during SHIFT/DONE is ignored and the transaction completes with ack.
REQ-023 cyc still high in IDLE after a DONE starts a new transaction; spi_cs_n thus stays high for at least 2 cycles between transactions.
REQ-024 No more than one transaction is outstanding; no queueing.
REQ-025 Bit counter 7 bits (0..63), divider counter 8 bits; no wrap beyond 64 bits.

Reset
REQ-026 wb_rst_n=0 SHALL immediately force: state IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, ack=0, rdt=0, busy=0, counters 0.
REQ-027 Reset mid-transaction aborts with no ack; first request after release starts a fresh frame from the command byte.
REQ-028 A request with cyc already high at reset release is sampled on the first rising edge after release.

Verification
REQ-029 DIV=1, flash model returns byte = addr[7:0] at each address; cyc=1, adr=0x00123456 -> mosi bytes 03,12,34,56; ack after 130 edges; rdt=0x59585756.
REQ-030 DIV=3, adr=0x00100000 -> sck period 6 cycles, 64 rising edges, ack after 386 edges, rdt=0x03020100.
REQ-031 adr=0xFFFFFFFC, DIV=1 -> mosi address bytes FF,FF,FC (bits 31:24 not sent); rdt=0xFFFEFDFC per model wrap at 24 bits.
REQ-032 cyc dropped at cycle 10 of a transfer -> transfer still completes, one ack pulse, busy returns 0 the cycle after ack.
REQ-033 cyc held high for two reads (0x000010, 0x000020) -> rdt 0x13121110 then 0x23222120; spi_cs_n high for exactly 2 cycles between them.
REQ-034 wb_rst_n pulsed low at cycle 40 of a transfer -> spi_cs_n=1 and sck=0 without waiting for a clock edge, no ack; next request 0x000030 -> rdt=0x33323130.

Source files
------------

// File: rtl/spi_flash_read_if.sv
// Bus-side request/response signals of the SPI flash read engine.
interface spi_flash_read_if;
    logic        cyc;
    logic [31:0] adr;
    logic        ack;
    logic [31:0] rdt;
    logic        busy;

    modport master (output cyc, output adr, input ack, input rdt, input busy);
    modport slave  (input cyc, input adr, output ack, output rdt, output busy);
endinterface

// File: rtl/spi_flash_read.sv
// Single-word SPI flash reader: sends READ (0x03) + 24-bit address, shifts
// in four bytes and returns them as a little-endian word with a one-cycle ack.
module spi_flash_read #(
    parameter int unsigned DIV = 1
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    spi_flash_read_if.slave  bus,
    output logic             spi_cs_n,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(DIV);
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t      state_q, state_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        sck_q, sck_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;

    logic unused_adr_hi;
    assign unused_adr_hi = &{1'b0, bus.adr[31:24]};

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 7'd0;
            div_cnt_q <= 8'd0;
            sck_q     <= 1'b0;
            tx_q      <= 32'd0;
            rx_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
        end
    end

    // The divider is loaded with DIV (not DIV-1) on entry, giving one extra
    // low cycle of chip-select setup; bit_cnt reaching 64 adds one hold cycle.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        case (state_q)
            IDLE: begin
                if (bus.cyc) begin
                    state_d   = SHIFT;
                    tx_d      = {8'h03, bus.adr[23:0]};
                    rx_d      = 32'd0;
                    bit_cnt_d = 7'd0;
                    div_cnt_d = DIV_LOAD;
                    sck_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt_q[6]) begin
                    state_d   = DONE;
                    bit_cnt_d = 7'd0;
                    div_cnt_d = 8'd0;
                end else if (div_cnt_q != 8'd0) begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end else begin
                    div_cnt_d = DIV_LAST;
                    sck_d     = ~sck_q;
                    if (!sck_q) begin
                        // Rising edge: only the data half of the frame is kept.
                        if (bit_cnt_q[5]) begin
                            rx_d = {rx_q[30:0], spi_miso};
                        end
                    end else begin
                        tx_d      = {tx_q[30:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ack  = (state_q == DONE);
    assign bus.busy = (state_q != IDLE);
    assign bus.rdt  = bus.ack ? {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]} : 32'd0;
    assign spi_cs_n = (state_q != SHIFT);
    assign spi_sck  = sck_q;
    assign spi_mosi = tx_q[31];

endmodule
